alu_exec_unit: RTL

Parametrised execute-stage ALU with an integrated control decoder. It decodes the 2-bit ALU operation class plus the 6-bit function code, then performs the operation and returns a registered result through a valid/ready handshake. It covers the decoder's full MIPS R-type subset, including the unsigned, shift and jump-register functions that previously mapped to the "unsupported" code. It sits between the register-read stage and the memory/branch logic of the datapath.

---
 rtl/alu_pkg.sv | 51 +++++
 rtl/alu_decode.sv | 40 ++++
 rtl/alu_exec_unit.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared ALU control codes, R-type function codes and FSM state encoding.
// ALU_SERIAL_SHIFT_EN adds the SHIFT state used by the serial shifter.
package alu_pkg;

    localparam int unsigned CTL_W  = 4;
    localparam int unsigned FUNC_W = 6;

    localparam logic [CTL_W-1:0] CTL_AND     = 4'd0;
    localparam logic [CTL_W-1:0] CTL_OR      = 4'd1;
    localparam logic [CTL_W-1:0] CTL_ADD     = 4'd2;
    localparam logic [CTL_W-1:0] CTL_ADDU    = 4'd3;
    localparam logic [CTL_W-1:0] CTL_SUBU    = 4'd4;
    localparam logic [CTL_W-1:0] CTL_SLTU    = 4'd5;
    localparam logic [CTL_W-1:0] CTL_SUB     = 4'd6;
    localparam logic [CTL_W-1:0] CTL_SLT     = 4'd7;
    localparam logic [CTL_W-1:0] CTL_SLL     = 4'd8;
    localparam logic [CTL_W-1:0] CTL_SRL     = 4'd9;
    localparam logic [CTL_W-1:0] CTL_JR      = 4'd10;
    localparam logic [CTL_W-1:0] CTL_NOR     = 4'd12;
    localparam logic [CTL_W-1:0] CTL_ILLEGAL = 4'd15;

    localparam logic [FUNC_W-1:0] FN_SLL  = 6'd0;
    localparam logic [FUNC_W-1:0] FN_SRL  = 6'd2;
    localparam logic [FUNC_W-1:0] FN_JR   = 6'd8;
    localparam logic [FUNC_W-1:0] FN_ADD  = 6'd32;
    localparam logic [FUNC_W-1:0] FN_ADDU = 6'd33;
    localparam logic [FUNC_W-1:0] FN_SUB  = 6'd34;
    localparam logic [FUNC_W-1:0] FN_SUBU = 6'd35;
    localparam logic [FUNC_W-1:0] FN_AND  = 6'd36;
    localparam logic [FUNC_W-1:0] FN_OR   = 6'd37;
    localparam logic [FUNC_W-1:0] FN_NOR  = 6'd39;
    localparam logic [FUNC_W-1:0] FN_SLT  = 6'd42;
    localparam logic [FUNC_W-1:0] FN_SLTU = 6'd43;

    localparam logic [1:0] OP_ADD   = 2'd0;
    localparam logic [1:0] OP_SUB   = 2'd1;
    localparam logic [1:0] OP_RTYPE = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
`ifdef ALU_SERIAL_SHIFT_EN
        ST_SHIFT = 2'd1,
`endif
        ST_HOLD  = 2'd2
    } state_t;

    function automatic logic is_shift(input logic [CTL_W-1:0] ctl);
        return (ctl == CTL_SLL) || (ctl == CTL_SRL);
    endfunction

endpackage

// File: rtl/alu_decode.sv
// Combinational ALU control decoder: (alu_op, func_code) -> control code + illegal.
module alu_decode
    import alu_pkg::*;
(
    input  logic [1:0]        alu_op,
    input  logic [FUNC_W-1:0] func_code,
    output logic [CTL_W-1:0]  ctl,
    output logic              illegal
);

    // lw/sw and beq use the wrapping forms so they can never raise overflow
    always_comb begin
        ctl     = CTL_ILLEGAL;
        illegal = 1'b0;
        case (alu_op)
            OP_ADD:   ctl = CTL_ADDU;
            OP_SUB:   ctl = CTL_SUBU;
            OP_RTYPE: begin
                case (func_code)
                    FN_SLL:  ctl = CTL_SLL;
                    FN_SRL:  ctl = CTL_SRL;
                    FN_JR:   ctl = CTL_JR;
                    FN_ADD:  ctl = CTL_ADD;
                    FN_ADDU: ctl = CTL_ADDU;
                    FN_SUB:  ctl = CTL_SUB;
                    FN_SUBU: ctl = CTL_SUBU;
                    FN_AND:  ctl = CTL_AND;
                    FN_OR:   ctl = CTL_OR;
                    FN_NOR:  ctl = CTL_NOR;
                    FN_SLT:  ctl = CTL_SLT;
                    FN_SLTU: ctl = CTL_SLTU;
                    default: ctl = CTL_ILLEGAL;
                endcase
            end
            default:  ctl = CTL_ILLEGAL;
        endcase
        illegal = (ctl == CTL_ILLEGAL);
    end

endmodule

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU with integrated decoder and registered valid/ready output.
// ALU_SERIAL_SHIFT_EN selects a 1-bit/cycle serial shifter instead of a barrel shifter.
module alu_exec_unit
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SHW   = $clog2(WIDTH)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        alu_op,
    input  logic [FUNC_W-1:0] func_code,
    input  logic [SHW-1:0]    shamt,
    input  logic [WIDTH-1:0]  operand_a,
    input  logic [WIDTH-1:0]  operand_b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  result,
    output logic              zero,
    output logic              overflow,
    output logic              illegal
);

    state_t             state, state_d;
    logic [CTL_W-1:0]   ctl;
    logic               dec_illegal;
    logic               accept;
    logic [WIDTH-1:0]   sum, diff, calc;
    logic               calc_ovf;

    alu_decode u_decode (
        .alu_op    (alu_op),
        .func_code (func_code),
        .ctl       (ctl),
        .illegal   (dec_illegal)
    );

    assign sum  = operand_a + operand_b;
    assign diff = operand_a - operand_b;

    // Single-cycle datapath; illegal codes fall through to a zero result
    always_comb begin
        calc     = '0;
        calc_ovf = 1'b0;
        case (ctl)
            CTL_AND:  calc = operand_a & operand_b;
            CTL_OR:   calc = operand_a | operand_b;
            CTL_NOR:  calc = ~(operand_a | operand_b);
            CTL_ADD: begin
                calc     = sum;
                calc_ovf = (operand_a[WIDTH-1] == operand_b[WIDTH-1]) &&
                           (sum[WIDTH-1] != operand_a[WIDTH-1]);
            end
            CTL_ADDU: calc = sum;
            CTL_SUB: begin
                calc     = diff;
                calc_ovf = (operand_a[WIDTH-1] != operand_b[WIDTH-1]) &&
                           (diff[WIDTH-1] != operand_a[WIDTH-1]);
            end
            CTL_SUBU: calc = diff;
            CTL_SLT:  calc = WIDTH'($signed(operand_a) < $signed(operand_b));
            CTL_SLTU: calc = WIDTH'(operand_a < operand_b);
            CTL_SLL:  calc = operand_b << shamt;
            CTL_SRL:  calc = operand_b >> shamt;
            CTL_JR:   calc = operand_a;
            default:  calc = '0;
        endcase
    end

`ifdef ALU_SERIAL_SHIFT_EN
    logic [WIDTH-1:0] work, work_nxt;
    logic [SHW-1:0]   cnt;
    logic             shift_left;
    logic             serial_start;

    assign serial_start = is_shift(ctl) && (shamt != '0);
    assign work_nxt     = shift_left ? (work << 1) : (work >> 1);
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_d;
        end
    end

    // in_ready depends only on state and out_ready
    always_comb begin
        state_d  = state;
        in_ready = 1'b0;
        case (state)
            ST_IDLE: in_ready = 1'b1;
            ST_HOLD: in_ready = out_ready;
            default: in_ready = 1'b0;
        endcase
        accept = in_valid && in_ready;
        if (accept) begin
`ifdef ALU_SERIAL_SHIFT_EN
            state_d = serial_start ? ST_SHIFT : ST_HOLD;
`else
            state_d = ST_HOLD;
`endif
        end else if ((state == ST_HOLD) && out_ready) begin
            state_d = ST_IDLE;
        end
`ifdef ALU_SERIAL_SHIFT_EN
        else if ((state == ST_SHIFT) && (cnt == SHW'(1))) begin
            state_d = ST_HOLD;
        end
`endif
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            out_valid  <= 1'b0;
            result     <= '0;
            zero       <= 1'b0;
            overflow   <= 1'b0;
            illegal    <= 1'b0;
`ifdef ALU_SERIAL_SHIFT_EN
            work       <= '0;
            cnt        <= '0;
            shift_left <= 1'b0;
`endif
        end else if (accept) begin
`ifdef ALU_SERIAL_SHIFT_EN
            if (serial_start) begin
                work       <= operand_b;
                cnt        <= shamt;
                shift_left <= (ctl == CTL_SLL);
                out_valid  <= 1'b0;
            end else
`endif
            begin
                result    <= calc;
                zero      <= (calc == '0);
                overflow  <= calc_ovf;
                illegal   <= dec_illegal;
                out_valid <= 1'b1;
            end
        end else if ((state == ST_HOLD) && out_ready) begin
            out_valid <= 1'b0;
        end
`ifdef ALU_SERIAL_SHIFT_EN
        else if (state == ST_SHIFT) begin
            work <= work_nxt;
            cnt  <= cnt - SHW'(1);
            if (cnt == SHW'(1)) begin
                result    <= work_nxt;
                zero      <= (work_nxt == '0);
                overflow  <= 1'b0;
                illegal   <= 1'b0;
                out_valid <= 1'b1;
            end
        end
`endif
    end

endmodule
